// File: rtl/fifo_uart_drain_pkg.sv
// Shared types and frame constants for the FIFO-to-UART drain block.
package fifo_uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_e;

    localparam int unsigned FRAME_BITS = 10;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

endpackage

// File: rtl/fifo_uart_drain_if.sv
// FIFO read port plus UART line and debug status of the drain block.
interface fifo_uart_drain_if #(
    parameter int unsigned COUNT_WIDTH = 16
) ();
    logic                   enable;
    logic [7:0]             fifo_data_out;
    logic                   fifo_empty;
    logic                   fifo_request_output;
    logic                   tx;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] frames_sent;

    modport master (
        output enable, fifo_data_out, fifo_empty,
        input  fifo_request_output, tx, busy, frames_sent
    );

    modport slave (
        input  enable, fifo_data_out, fifo_empty,
        output fifo_request_output, tx, busy, frames_sent
    );
endinterface

// File: rtl/fifo_uart_drain_serializer.sv
// 8N1 LSB-first serializer: start_i loads a byte, done_o pulses in the last stop-bit cycle.
module uart_tx_serializer
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BAUD = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o
);
    localparam int unsigned       BAUD_W    = $clog2(CLOCKS_PER_BAUD);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [3:0]        IDX_LAST  = 4'(FRAME_BITS - 1);

    logic [BAUD_W-1:0] baud_q;
    logic [3:0]        idx_q;
    logic [8:0]        shift_q;
    logic              active_q;
    logic              tx_q;
    logic              wrap;

    assign wrap   = active_q && (baud_q == BAUD_LAST);
    assign done_o = wrap && (idx_q == IDX_LAST);
    assign tx_o   = tx_q;

    // tx_q already carries the start bit when the first SEND cycle begins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            active_q <= 1'b0;
            tx_q     <= STOP_BIT;
        end else if (start_i) begin
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= {STOP_BIT, data_i};
            active_q <= 1'b1;
            tx_q     <= START_BIT;
        end else if (active_q) begin
            if (wrap) begin
                baud_q <= '0;
                if (idx_q == IDX_LAST) begin
                    active_q <= 1'b0;
                    tx_q     <= STOP_BIT;
                end else begin
                    idx_q   <= idx_q + 4'd1;
                    tx_q    <= shift_q[0];
                    shift_q <= {STOP_BIT, shift_q[8:1]};
                end
            end else begin
                baud_q <= baud_q + BAUD_W'(1);
            end
        end
    end
endmodule

// File: rtl/fifo_uart_drain.sv
// Pops bytes from the response FIFO and sends each as one UART frame; counts completed frames.
module fifo_uart_drain
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BAUD = 868,
    parameter int unsigned COUNT_WIDTH     = 16
) (
    input logic              clk,
    input logic              rst,
    fifo_uart_drain_if.slave bus
);
    if (CLOCKS_PER_BAUD < 2 || CLOCKS_PER_BAUD > 65535) begin : g_bad_baud
        $error("CLOCKS_PER_BAUD must be within 2..65535");
    end

    state_e                 state_q;
    logic [7:0]             data_q;
    logic [COUNT_WIDTH-1:0] frames_q;
    logic                   pop;
    logic                   ser_tx;
    logic                   ser_done;

    // Strobe is decoded in the IDLE cycle itself so the FIFO returns data during FETCH
    assign pop = (state_q == IDLE) && bus.enable && !bus.fifo_empty && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            frames_q <= '0;
        end else begin
            case (state_q)
                IDLE:    if (pop) state_q <= FETCH;
                FETCH: begin
                    data_q  <= bus.fifo_data_out;
                    state_q <= CAPTURE;
                end
                CAPTURE: state_q <= SEND;
                SEND: begin
                    if (ser_done) begin
                        frames_q <= frames_q + COUNT_WIDTH'(1);
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    uart_tx_serializer #(
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .start_i(state_q == CAPTURE),
        .data_i (data_q),
        .tx_o   (ser_tx),
        .done_o (ser_done)
    );

    assign bus.fifo_request_output = pop;
    assign bus.tx                  = ser_tx;
    assign bus.busy                = (state_q != IDLE);
    assign bus.frames_sent         = frames_q;
endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain with a behavioural FIFO, CLOCKS_PER_BAUD=4, COUNT_WIDTH=2.
module tb_fifo_uart_drain;
    localparam int unsigned CPB = 4;
    localparam int unsigned CW  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_uart_drain_if #(.COUNT_WIDTH(CW)) bus ();

    fifo_uart_drain #(
        .CLOCKS_PER_BAUD(CPB),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0]    mem [0:31];
    int            wr_ptr  = 0;
    int            rd_ptr  = 0;
    int            pop_cnt = 0;
    int            bad_pop = 0;
    int            cyc     = 0;
    int            n_vec   = 0;
    int            n_err   = 0;
    logic [CW-1:0] exp_frames;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    // FIFO read port: data valid the cycle after an accepted pop, junk otherwise
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_request_output === 1'b1) begin
            if (wr_ptr != rd_ptr) begin
                bus.fifo_data_out <= mem[rd_ptr % 32];
                rd_ptr  <= rd_ptr + 1;
                pop_cnt <= pop_cnt + 1;
            end else begin
                bad_pop <= bad_pop + 1;
            end
        end else begin
            bus.fifo_data_out <= 8'($urandom);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 32] = b;
        wr_ptr++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_frames = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_pop(input string tag, output int s);
        bit found = 1'b0;
        s = -1;
        #1;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bus.fifo_request_output === 1'b1) begin
                s = cyc;
                found = 1'b1;
            end else begin
                tick();
            end
        end
        if (!found) check({tag, "_pop_timeout"}, 64'd0, 64'd1);
    endtask

    // Called in the pop-strobe cycle; checks two idle cycles, 40 frame cycles, then the IDLE cycle
    task automatic check_frame(input string tag, input logic [9:0] frame, input int drop_k);
        logic [39:0] got;
        logic [39:0] exp;
        logic [1:0]  pre;
        int          busy_lo = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            pre[i] = bus.tx;
            if (bus.busy !== 1'b1) busy_lo++;
        end
        check({tag, "_idle_before_start"}, 64'(pre), 64'h3);
        for (int k = 0; k < 40; k++) begin
            tick();
            got[k] = bus.tx;
            exp[k] = frame[k / CPB];
            if (bus.busy !== 1'b1) busy_lo++;
            if (k == drop_k) bus.enable = 1'b0;
        end
        check({tag, "_tx_bits"}, 64'(got), 64'(exp));
        check({tag, "_busy_low_cycles"}, 64'(busy_lo), 64'd0);
        tick();
        exp_frames = exp_frames + CW'(1);
        check({tag, "_frames_sent"}, 64'(bus.frames_sent), 64'(exp_frames));
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        check({tag, "_tx_after"}, 64'(bus.tx), 64'd1);
    endtask

    initial begin
        int s, s1, s2, p0, t0, req_hi, tx_lo;
        rst = 1'b1;
        bus.enable = 1'b0;
        exp_frames = '0;
        repeat (3) tick();
        check("rst_tx", 64'(bus.tx), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_frames", 64'(bus.frames_sent), 64'd0);
        check("rst_req", 64'(bus.fifo_request_output), 64'd0);
        rst = 1'b0;
        tick();

        // Empty FIFO with enable high
        bus.enable = 1'b1;
        p0 = pop_cnt; req_hi = 0; tx_lo = 0;
        repeat (100) begin
            tick();
            if (bus.fifo_request_output !== 1'b0) req_hi++;
            if (bus.tx !== 1'b1) tx_lo++;
        end
        check("empty_req_cycles", 64'(req_hi), 64'd0);
        check("empty_tx_low_cycles", 64'(tx_lo), 64'd0);
        check("empty_pops", 64'(pop_cnt - p0), 64'd0);

        // Single byte 0xA5
        p0 = pop_cnt;
        push(8'hA5);
        wait_pop("a5", s);
        check_frame("a5", 10'b1101001010, -1);
        repeat (20) tick();
        check("a5_pops", 64'(pop_cnt - p0), 64'd1);

        // Three bytes back to back
        do_reset();
        push(8'h00); push(8'hFF); push(8'h55);
        wait_pop("b2b0", s1);
        check_frame("b2b0", 10'b1000000000, -1);
        wait_pop("b2b1", s2);
        check("b2b_gap1", 64'(s2 - s1), 64'd43);
        check_frame("b2b1", 10'b1111111110, -1);
        wait_pop("b2b2", s1);
        check("b2b_gap2", 64'(s1 - s2), 64'd43);
        check_frame("b2b2", 10'b1010101010, -1);

        // enable dropped during bit 4 of the first frame
        do_reset();
        bus.enable = 1'b1;
        p0 = pop_cnt;
        push(8'h11); push(8'h22); push(8'h33);
        wait_pop("en0", s);
        check_frame("en0", 10'b1000100010, 17);
        req_hi = 0;
        repeat (30) begin
            tick();
            if (bus.fifo_request_output !== 1'b0) req_hi++;
        end
        check("en_off_req_cycles", 64'(req_hi), 64'd0);
        check("en_off_pops", 64'(pop_cnt - p0), 64'd1);
        check("en_off_busy", 64'(bus.busy), 64'd0);
        bus.enable = 1'b1;
        t0 = cyc;
        wait_pop("en1", s);
        check("en_resume_delay", 64'(s - t0), 64'd0);
        check_frame("en1", 10'b1001000100, -1);
        wait_pop("en2", s);
        check_frame("en2", 10'b1001100110, -1);

        // Asynchronous reset during the start bit
        push(8'h3C);
        wait_pop("mid", s);
        tick(); tick(); tick();
        check("mid_start_bit", 64'(bus.tx), 64'd0);
        rst = 1'b1;
        exp_frames = '0;
        #1;
        check("mid_rst_tx", 64'(bus.tx), 64'd1);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_frames", 64'(bus.frames_sent), 64'd0);
        p0 = pop_cnt; req_hi = 0;
        push(8'hA5);
        repeat (5) begin
            tick();
            if (bus.fifo_request_output !== 1'b0) req_hi++;
        end
        check("mid_rst_req_cycles", 64'(req_hi), 64'd0);
        check("mid_rst_pops", 64'(pop_cnt - p0), 64'd0);
        rst = 1'b0;

        // Frame counter wrap at COUNT_WIDTH=2: 1,2,3,0,1
        wait_pop("wrap0", s);
        check_frame("wrap0", 10'b1101001010, -1);
        push(8'h00); push(8'hFF); push(8'h55); push(8'hA5);
        wait_pop("wrap1", s);
        check_frame("wrap1", 10'b1000000000, -1);
        wait_pop("wrap2", s);
        check_frame("wrap2", 10'b1111111110, -1);
        wait_pop("wrap3", s);
        check_frame("wrap3", 10'b1010101010, -1);
        wait_pop("wrap4", s);
        check_frame("wrap4", 10'b1101001010, -1);

        repeat (10) tick();
        check("pops_while_empty", 64'(bad_pop), 64'd0);
        check("fifo_drained", 64'(bus.fifo_empty), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
